// File: rtl/seq_detector_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
package seq_detector_pkg;

  // One-hot encoding, so the two unused codes exist and are steered back to SEARCH.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  localparam logic MODE_LATCH = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b10100;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a clear that beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, latch/pulse modes and a match counter.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W     = 5,
  parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(DEFAULT_PATTERN),
  parameter int               REL_ZEROS = 5,
  parameter int               CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             mode,
  input  logic             pattern_ld,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             count_clr,
  output logic             valid,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(PAT_W);
  localparam int ZW = $clog2(REL_ZEROS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);
  localparam logic [ZW-1:0] ZCNT_LAST = ZW'(REL_ZEROS - 1);

  state_t           state;
  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [ZW-1:0]    zcnt;
  logic [PAT_W-1:0] window;
  logic             match_now;

  // The window is the history plus the bit arriving this cycle; its low bits are also the next history.
  assign window    = {hist, s_in};
  assign match_now = s_valid && (state == ST_SEARCH) && (fill == FILL_MAX) && (window == pat_reg);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_SEARCH;
      pat_reg     <= PATTERN;
      hist        <= '0;
      fill        <= '0;
      zcnt        <= '0;
      valid       <= 1'b0;
      match_pulse <= 1'b0;
    end else if (pattern_ld) begin
      pat_reg     <= pattern_in;
      hist        <= '0;
      fill        <= '0;
      zcnt        <= '0;
      state       <= ST_SEARCH;
      valid       <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (s_valid) begin
            hist <= window[PAT_W-2:0];
            if (fill != FILL_MAX) begin
              fill <= fill + FW'(1);
            end
            if (match_now) begin
              match_pulse <= 1'b1;
              if (mode == MODE_LATCH) begin
                state <= ST_LOCKED;
                valid <= 1'b1;
                zcnt  <= '0;
              end
            end
          end
        end
        ST_LOCKED: begin
          // Pulse mode has no notion of a lock, so a mode change abandons it immediately.
          if (mode == MODE_PULSE) begin
            state <= ST_SEARCH;
            valid <= 1'b0;
            hist  <= '0;
            fill  <= '0;
            zcnt  <= '0;
          end else if (s_valid) begin
            if (s_in) begin
              zcnt <= '0;
            end else if (zcnt == ZCNT_LAST) begin
              state <= ST_SEARCH;
              valid <= 1'b0;
              hist  <= '0;
              fill  <= '0;
              zcnt  <= '0;
            end else begin
              zcnt <= zcnt + ZW'(1);
            end
          end
        end
        default: begin
          state <= ST_SEARCH;
          valid <= 1'b0;
          hist  <= '0;
          fill  <= '0;
          zcnt  <= '0;
        end
      endcase
    end
  end

  // A load in the same cycle discards the sample, so it must not count either.
  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clock (clock),
    .reset (reset),
    .inc   (match_now && !pattern_ld),
    .clr   (count_clr),
    .q     (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_seq_detector_param;

  typedef struct {
    int    dut;
    logic  v;
    logic  p;
    int    c;
    string name;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       s_in0, s_valid0, mode0, pattern_ld0, count_clr0;
  logic [4:0] pattern_in0;
  logic       valid0, match_pulse0;
  logic [7:0] match_count0;
  logic       s_in1, s_valid1, mode1, pattern_ld1, count_clr1;
  logic [4:0] pattern_in1;
  logic       valid1, match_pulse1;
  logic [1:0] match_count1;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   failures  = 0;

  seq_detector_param #(
    .PAT_W(5), .PATTERN(5'b10100), .REL_ZEROS(5), .CNT_W(8)
  ) dut0 (
    .clock(clock), .reset(reset), .s_in(s_in0), .s_valid(s_valid0), .mode(mode0),
    .pattern_ld(pattern_ld0), .pattern_in(pattern_in0), .count_clr(count_clr0),
    .valid(valid0), .match_pulse(match_pulse0), .match_count(match_count0)
  );

  seq_detector_param #(
    .PAT_W(5), .PATTERN(5'b10100), .REL_ZEROS(5), .CNT_W(2)
  ) dut1 (
    .clock(clock), .reset(reset), .s_in(s_in1), .s_valid(s_valid1), .mode(mode1),
    .pattern_ld(pattern_ld1), .pattern_in(pattern_in1), .count_clr(count_clr1),
    .valid(valid1), .match_pulse(match_pulse1), .match_count(match_count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input exp_t e);
    logic av, ap;
    int   ac;
    if (e.dut == 0) begin
      av = valid0; ap = match_pulse0; ac = int'(match_count0);
    end else begin
      av = valid1; ap = match_pulse1; ac = int'(match_count1);
    end
    tests_run++;
    if (av !== e.v || ap !== e.p || ac != e.c) begin
      failures++;
      $display("[TB] FAIL %s (dut%0d): got valid=%b pulse=%b count=%0d, expected valid=%b pulse=%b count=%0d",
               e.name, e.dut, av, ap, ac, e.v, e.p, e.c);
    end
  endtask

  // Outputs are registered, so one edge after the stimulus they must show the queued expectation.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0) begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int dut, input logic sv, input logic si, input logic md,
                               input logic ld, input logic [4:0] pin, input logic clr,
                               input logic ev, input logic ep, input int ec, input string nm);
    if (dut == 0) begin
      s_valid0 = sv; s_in0 = si; mode0 = md; pattern_ld0 = ld; pattern_in0 = pin; count_clr0 = clr;
      s_valid1 = 1'b0; pattern_ld1 = 1'b0; count_clr1 = 1'b0;
    end else begin
      s_valid1 = sv; s_in1 = si; mode1 = md; pattern_ld1 = ld; pattern_in1 = pin; count_clr1 = clr;
      s_valid0 = 1'b0; pattern_ld0 = 1'b0; count_clr0 = 1'b0;
    end
    exp_q.push_back('{dut, ev, ep, ec, nm});
    @(posedge clock);
    #2;
  endtask

  task automatic sendBit(input int dut, input logic b, input logic md,
                         input logic ev, input logic ep, input int ec, input string nm);
    applyStimulus(dut, 1'b1, b, md, 1'b0, 5'b0, 1'b0, ev, ep, ec, nm);
  endtask

  task automatic doReset(input string nm);
    reset = 1'b0;
    s_valid0 = 1'b0; pattern_ld0 = 1'b0; count_clr0 = 1'b0; mode0 = 1'b0;
    s_valid1 = 1'b0; pattern_ld1 = 1'b0; count_clr1 = 1'b0; mode1 = 1'b0;
    exp_q.push_back('{0, 1'b0, 1'b0, 0, nm});
    exp_q.push_back('{1, 1'b0, 1'b0, 0, nm});
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    s_in0 = 1'b0; pattern_in0 = 5'b0; s_in1 = 1'b0; pattern_in1 = 5'b0;
    doReset("reset_state");
    doReset("reset_state2");

    // Latch mode, default pattern, then release with five zeros
    sendBit(0, 1, 0, 0, 0, 0, "latch_b1");
    sendBit(0, 0, 0, 0, 0, 0, "latch_b2");
    sendBit(0, 1, 0, 0, 0, 0, "latch_b3");
    sendBit(0, 0, 0, 0, 0, 0, "latch_b4");
    sendBit(0, 0, 0, 1, 1, 1, "latch_match");
    for (int i = 0; i < 4; i++) sendBit(0, 0, 0, 1, 0, 1, "latch_hold_zero");
    sendBit(0, 0, 0, 0, 0, 1, "latch_release");

    // Relock, then a 1 inside the zero run restarts the release count
    sendBit(0, 1, 0, 0, 0, 1, "relock_b1");
    sendBit(0, 0, 0, 0, 0, 1, "relock_b2");
    sendBit(0, 1, 0, 0, 0, 1, "relock_b3");
    sendBit(0, 0, 0, 0, 0, 1, "relock_b4");
    sendBit(0, 0, 0, 1, 1, 2, "relock_match");
    for (int i = 0; i < 4; i++) sendBit(0, 0, 0, 1, 0, 2, "restart_zero_a");
    sendBit(0, 1, 0, 1, 0, 2, "restart_one");
    for (int i = 0; i < 4; i++) sendBit(0, 0, 0, 1, 0, 2, "restart_zero_b");
    sendBit(0, 0, 0, 0, 0, 2, "restart_release");

    // Idle cycles between qualified bits must not shift history
    sendBit(0, 1, 0, 0, 0, 2, "gap_b1");
    applyStimulus(0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 2, "gap_idle1");
    sendBit(0, 0, 0, 0, 0, 2, "gap_b2");
    applyStimulus(0, 0, 1, 0, 0, 5'b0, 0, 0, 0, 2, "gap_idle2");
    sendBit(0, 1, 0, 0, 0, 2, "gap_b3");
    applyStimulus(0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 2, "gap_idle3");
    sendBit(0, 0, 0, 0, 0, 2, "gap_b4");
    applyStimulus(0, 0, 1, 0, 0, 5'b0, 0, 0, 0, 2, "gap_idle4");
    sendBit(0, 0, 0, 1, 1, 3, "gap_match");
    applyStimulus(0, 0, 0, 0, 0, 5'b0, 0, 1, 0, 3, "gap_locked_idle");

    // Switching to pulse mode drops the lock; then clear the counter
    applyStimulus(0, 0, 0, 1, 0, 5'b0, 0, 0, 0, 3, "pulse_unlock");
    applyStimulus(0, 0, 0, 1, 0, 5'b0, 1, 0, 0, 0, "count_clear");

    // Overlapping matches with pattern 10101
    applyStimulus(0, 0, 0, 1, 1, 5'b10101, 0, 0, 0, 0, "load_10101");
    sendBit(0, 1, 1, 0, 0, 0, "ovl_b1");
    sendBit(0, 0, 1, 0, 0, 0, "ovl_b2");
    sendBit(0, 1, 1, 0, 0, 0, "ovl_b3");
    sendBit(0, 0, 1, 0, 0, 0, "ovl_b4");
    sendBit(0, 1, 1, 0, 1, 1, "ovl_match1");
    sendBit(0, 0, 1, 0, 0, 1, "ovl_b6");
    sendBit(0, 1, 1, 0, 1, 2, "ovl_match2");

    // Load mid-pattern discards partial history and the sample on the load cycle
    applyStimulus(0, 1, 1, 0, 1, 5'b10100, 0, 0, 0, 2, "load_10100");
    sendBit(0, 1, 0, 0, 0, 2, "mid_b1");
    sendBit(0, 0, 0, 0, 0, 2, "mid_b2");
    sendBit(0, 1, 0, 0, 0, 2, "mid_b3");
    sendBit(0, 0, 0, 0, 0, 2, "mid_b4");
    applyStimulus(0, 0, 0, 0, 1, 5'b10100, 0, 0, 0, 2, "mid_reload");
    sendBit(0, 0, 0, 0, 0, 2, "mid_no_match");
    sendBit(0, 1, 0, 0, 0, 2, "mid_c1");
    sendBit(0, 0, 0, 0, 0, 2, "mid_c2");
    sendBit(0, 1, 0, 0, 0, 2, "mid_c3");
    sendBit(0, 0, 0, 0, 0, 2, "mid_c4");
    sendBit(0, 0, 0, 1, 1, 3, "mid_match");

    // Reset while locked on a non-default pattern restores the default pattern
    applyStimulus(0, 0, 0, 0, 1, 5'b10101, 0, 0, 0, 3, "load_10101_latch");
    sendBit(0, 1, 0, 0, 0, 3, "rl_b1");
    sendBit(0, 0, 0, 0, 0, 3, "rl_b2");
    sendBit(0, 1, 0, 0, 0, 3, "rl_b3");
    sendBit(0, 0, 0, 0, 0, 3, "rl_b4");
    sendBit(0, 1, 0, 1, 1, 4, "rl_match");
    doReset("reset_mid_lock");
    sendBit(0, 1, 0, 0, 0, 0, "def_b1");
    sendBit(0, 0, 0, 0, 0, 0, "def_b2");
    sendBit(0, 1, 0, 0, 0, 0, "def_b3");
    sendBit(0, 0, 0, 0, 0, 0, "def_b4");
    sendBit(0, 0, 0, 1, 1, 1, "def_match");

    // Two-bit counter saturates at 3; clear beats a simultaneous match
    applyStimulus(1, 0, 0, 1, 1, 5'b10101, 0, 0, 0, 0, "sat_load");
    sendBit(1, 1, 1, 0, 0, 0, "sat_b1");
    sendBit(1, 0, 1, 0, 0, 0, "sat_b2");
    sendBit(1, 1, 1, 0, 0, 0, "sat_b3");
    sendBit(1, 0, 1, 0, 0, 0, "sat_b4");
    sendBit(1, 1, 1, 0, 1, 1, "sat_match1");
    sendBit(1, 0, 1, 0, 0, 1, "sat_b6");
    sendBit(1, 1, 1, 0, 1, 2, "sat_match2");
    sendBit(1, 0, 1, 0, 0, 2, "sat_b8");
    sendBit(1, 1, 1, 0, 1, 3, "sat_match3");
    sendBit(1, 0, 1, 0, 0, 3, "sat_b10");
    sendBit(1, 1, 1, 0, 1, 3, "sat_match4_hold");
    sendBit(1, 0, 1, 0, 0, 3, "sat_b12");
    applyStimulus(1, 1, 1, 1, 0, 5'b0, 1, 0, 1, 0, "sat_clr_wins");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector, successor to the team's fixed 5-bit "10100" detector.
- Programmable pattern of PAT_W bits, runtime-loadable.
- Two modes: latch mode (lock until a run of REL_ZEROS zeros is seen) and pulse mode (overlapping detection, no lock).
- Sits on a 1-bit serial input with a sample qualifier; reports matches to control logic via level, pulse and a saturating match counter.

Parameters:
PAT_W, 5, pattern length in bits; must be >= 2.
PATTERN, 5'b10100, reset value of the pattern register; MSB is the first bit received.
REL_ZEROS, 5, consecutive sampled zeros that release the lock; must be >= 1.
CNT_W, 8, width of match_count.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (reset=0 resets on the clock edge)
s_in  input  1  serial data bit
s_valid  input  1  s_in is sampled only on cycles with s_valid=1
mode  input  1  0 = latch mode, 1 = pulse (overlapping) mode
pattern_ld  input  1  load pattern_in into the pattern register
pattern_in  input  PAT_W  new pattern
count_clr  input  1  clear match_count
valid  output  1  registered; 1 while state is LOCKED
match_pulse  output  1  registered; one-cycle pulse per detected match
match_count  output  CNT_W  registered; saturating count of matches

Behaviour:
- Reset (reset=0 at an edge) sets: state=SEARCH, pat_reg=PATTERN, hist=0, fill=0, zcnt=0, valid=0, match_pulse=0, match_count=0.
- State encoding: SEARCH, LOCKED. Any illegal encoding goes to SEARCH on the next edge.
- hist: PAT_W-1 bit shift register of the most recent sampled bits.
- fill: number of valid bits held in hist, saturating at PAT_W-1; width $clog2(PAT_W).
- Match condition (combinational): match_now = s_valid & state==SEARCH & fill==PAT_W-1 & {hist, s_in}==pat_reg.
- Latency: valid and match_pulse assert on the edge that samples the completing bit, so they are visible the following cycle.
- SEARCH, s_valid=1: shift s_in into hist and increment fill (saturating).
  - On match_now with mode=0: state becomes LOCKED, valid=1, match_pulse=1, zcnt=0.
  - On match_now with mode=1: match_pulse=1, state stays SEARCH, and hist keeps shifting, so matches may overlap.
- SEARCH, s_valid=0: no change; match_pulse=0.
- LOCKED, s_valid=1:
  - s_in=0 increments zcnt.
  - s_in=1 clears zcnt.
  - When the sample is a zero and zcnt==REL_ZEROS-1: state becomes SEARCH, valid=0, hist=0, fill=0, zcnt=0.
- LOCKED: detection is suppressed, hist does not shift, and match_count is frozen.
- LOCKED with mode=1 on any cycle: go to SEARCH next edge with hist, fill and zcnt cleared.
- match_count:
  - Increments by 1 on every match_now.
  - Holds at 2^CNT_W-1 once reached (saturation).
  - count_clr=1 forces 0; count_clr wins over a simultaneous match.
- pattern_ld=1 has highest priority after reset:
  - pat_reg<=pattern_in; hist, fill and zcnt cleared; state=SEARCH; valid=0; match_pulse=0.
  - The s_in sample in that cycle is discarded and match_count is untouched.
- match_pulse is 0 on every cycle without a match_now on the previous edge.
- Reset mid-lock or mid-pattern: full reset state on that edge, and pat_reg returns to PATTERN.

Decomposition:
- Package seq_detector_pkg:
  - state localparams ST_SEARCH, ST_LOCKED;
  - mode constants MODE_LATCH=0, MODE_PULSE=1;
  - default pattern constant.
- One sub-module, sat_counter (parameter W; inputs clock, reset, inc, clr; output q), instantiated for match_count.
- FSM, hist/fill and zcnt stay in the top module.

Test Plan:
- Latch-mode default pattern:
  - mode=0, s_valid=1, stream 1,0,1,0,0 -> cycle after 5th bit: valid=1, match_pulse=1 for exactly one cycle, match_count=1.
  - Then 5 zeros -> valid=0 the cycle after the 5th zero.
- Release restart: while LOCKED, send 0,0,0,0,1 then 0,0,0,0,0 -> valid stays 1 through the first 9 samples and drops after the 10th; the extra 1 causes no count increment.
- Overlap in pulse mode:
  - pattern_ld with pattern_in=5'b10101, mode=1, stream 1,0,1,0,1,0,1 -> match_pulse after samples 5 and 7, match_count=2, valid always 0.
- s_valid gaps: default pattern with s_valid=0 idle cycles inserted between every bit -> a single match after the 5th qualified bit; idle cycles do not shift hist.
- Saturation and clear:
  - CNT_W=2, mode=1, 4 matches -> match_count=3.
  - count_clr asserted on the same cycle as a 5th match -> match_count=0.
- Reset and load mid-operation:
  - reset=0 while LOCKED -> next cycle valid=0, match_count=0, pattern back to 10100.
  - pattern_ld after 4 bits of a match -> partial history discarded; a 5th bit does not match.
